branch_target_predictor: RTL and testbench

Parametrised branch target buffer with per-entry saturating direction counters. It replaces the single-bit "nonzero target means taken" memo in the fetch stage of the 5-stage pipeline. IF presents the fetch PC every cycle and receives a registered hit/taken/target prediction one cycle later. The stage that resolves branches (MEM) writes outcomes back through an update port. The block adds tag checking, hysteresis, explicit invalidation and stall hold.

---
 rtl/branch_target_predictor.sv | 102 ++++++++++
 tb/tb_branch_target_predictor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Registered lookup (read-before-write against same-edge updates), update port, flush and clock enable.
module branch_target_predictor #(
    parameter int ENTRIES = 64,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 8,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_ce,
    input  logic [ADDR_W-1:0] w_lk_pc,
    output logic              r_pred_hit,
    output logic              r_pred_taken,
    output logic [ADDR_W-1:0] r_pred_target,
    input  logic              w_up_valid,
    input  logic [ADDR_W-1:0] w_up_pc,
    input  logic              w_up_taken,
    input  logic [ADDR_W-1:0] w_up_target,
    input  logic              w_flush
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CNT_W-1:0]   r_cnt    [ENTRIES];

    logic [INDEX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [INDEX_W-1:0] w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_lk_hit;
    logic               w_up_hit;
    logic               w_up_en;
    logic               w_alloc;
    logic               w_unused;

    assign w_lk_idx = w_lk_pc[INDEX_W+1:2];
    assign w_lk_tag = w_lk_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign w_up_idx = w_up_pc[INDEX_W+1:2];
    assign w_up_tag = w_up_pc[INDEX_W+TAG_W+1:INDEX_W+2];

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // A flush in the same cycle swallows the update entirely.
    assign w_up_en  = w_ce && w_up_valid && !w_flush;
    assign w_alloc  = w_up_en && w_up_taken && !w_up_hit;

    // PC bits outside the index/tag fields are deliberately ignored.
    assign w_unused = &{w_lk_pc, w_up_pc};

    // Stage boundary: valid bits and registered prediction.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_valid       <= '0;
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else if (w_ce) begin
            r_pred_hit    <= w_lk_hit;
            r_pred_taken  <= w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];
            r_pred_target <= w_lk_hit ? r_target[w_lk_idx] : '0;
            if (w_flush) begin
                r_valid <= '0;
            end else if (w_alloc) begin
                r_valid[w_up_idx] <= 1'b1;
            end
        end
    end

    // Tag/target/counter storage needs no reset: unreachable while invalid.
    always_ff @(posedge w_clk) begin
        if (w_up_en) begin
            if (w_up_hit) begin
                if (w_up_taken) begin
                    r_cnt[w_up_idx]    <= sat_inc(r_cnt[w_up_idx]);
                    r_target[w_up_idx] <= w_up_target;
                end else begin
                    r_cnt[w_up_idx]    <= sat_dec(r_cnt[w_up_idx]);
                end
            end else if (w_up_taken) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= w_up_target;
                r_cnt[w_up_idx]    <= CNT_WEAK;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed and randomized bench for branch_target_predictor against a table-level reference model.
module tb_branch_target_predictor;

    logic        w_clk;
    logic        w_rst_n;
    logic        w_ce;
    logic [31:0] w_lk_pc;
    logic        r_pred_hit;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic        w_up_valid;
    logic [31:0] w_up_pc;
    logic        w_up_taken;
    logic [31:0] w_up_target;
    logic        w_flush;

    int checks   = 0;
    int failures = 0;

    // Reference model: one record per table slot, plain integers.
    bit          m_valid [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;

    branch_target_predictor dut (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .w_ce         (w_ce),
        .w_lk_pc      (w_lk_pc),
        .r_pred_hit   (r_pred_hit),
        .r_pred_taken (r_pred_taken),
        .r_pred_target(r_pred_target),
        .w_up_valid   (w_up_valid),
        .w_up_pc      (w_up_pc),
        .w_up_taken   (w_up_taken),
        .w_up_target  (w_up_target),
        .w_flush      (w_flush)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc / 256) % 256);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        e_hit = 1'b0;
        e_taken = 1'b0;
        e_tgt = '0;
    endtask

    task automatic check_model(input string tag);
        checks++;
        assert (r_pred_hit === e_hit) else begin
            failures++;
            $error("FAIL %s hit: got %0b want %0b", tag, r_pred_hit, e_hit);
        end
        checks++;
        assert (r_pred_taken === e_taken) else begin
            failures++;
            $error("FAIL %s taken: got %0b want %0b", tag, r_pred_taken, e_taken);
        end
        checks++;
        assert (r_pred_target === e_tgt) else begin
            failures++;
            $error("FAIL %s target: got %h want %h", tag, r_pred_target, e_tgt);
        end
    endtask

    task automatic expect_out(input string tag, input logic h, input logic t, input logic [31:0] tg);
        checks++;
        assert (r_pred_hit === h && r_pred_taken === t && r_pred_target === tg) else begin
            failures++;
            $error("FAIL %s: got hit=%0b taken=%0b tgt=%h want hit=%0b taken=%0b tgt=%h",
                   tag, r_pred_hit, r_pred_taken, r_pred_target, h, t, tg);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input logic ce, input logic [31:0] lk, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                        input logic fl, input string tag);
        int i;
        int u;
        bit h;
        bit uh;
        w_ce = ce; w_lk_pc = lk; w_up_valid = uv; w_up_pc = upc;
        w_up_taken = ut; w_up_target = utg; w_flush = fl;
        if (ce) begin
            i = idx_of(lk);
            h = m_valid[i] && (m_tag[i] == tag_of(lk));
            e_hit = h;
            e_taken = h && (m_cnt[i] >= 2);
            e_tgt = h ? m_tgt[i] : 32'h0;
            if (fl) begin
                for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
            end else if (uv) begin
                u = idx_of(upc);
                uh = m_valid[u] && (m_tag[u] == tag_of(upc));
                if (uh && ut) begin
                    m_cnt[u] = (m_cnt[u] == 3) ? 3 : m_cnt[u] + 1;
                    m_tgt[u] = utg;
                end else if (uh) begin
                    m_cnt[u] = (m_cnt[u] == 0) ? 0 : m_cnt[u] - 1;
                end else if (ut) begin
                    m_valid[u] = 1'b1;
                    m_tag[u] = tag_of(upc);
                    m_tgt[u] = utg;
                    m_cnt[u] = 2;
                end
            end
        end
        @(posedge w_clk);
        #1;
        check_model(tag);
    endtask

    task automatic look(input logic [31:0] lk, input string tag);
        step(1'b1, lk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, tag);
    endtask

    task automatic upd(input logic [31:0] lk, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input string tag);
        step(1'b1, lk, 1'b1, upc, ut, utg, 1'b0, tag);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] rup;
        w_rst_n = 1'b0; w_ce = 1'b0; w_lk_pc = '0; w_up_valid = 1'b0;
        w_up_pc = '0; w_up_taken = 1'b0; w_up_target = '0; w_flush = 1'b0;
        model_reset();
        repeat (2) @(posedge w_clk);
        #1;
        expect_out("reset_outputs", 1'b0, 1'b0, 32'h0);
        #2 w_rst_n = 1'b1;

        look(32'h40, "empty_lookup");
        expect_out("empty_const", 1'b0, 1'b0, 32'h0);
        upd(32'h40, 32'h40, 1'b1, 32'h100, "alloc");
        look(32'h40, "alloc_hit");
        expect_out("alloc_hit_const", 1'b1, 1'b1, 32'h100);

        for (int k = 0; k < 3; k++) upd(32'h40, 32'h40, 1'b1, 32'h100, "sat_up");
        for (int k = 0; k < 2; k++) upd(32'h40, 32'h40, 1'b0, 32'h0, "dec");
        look(32'h40, "cnt1");
        expect_out("cnt1_const", 1'b1, 1'b0, 32'h100);
        upd(32'h40, 32'h40, 1'b1, 32'h100, "inc2");
        look(32'h40, "cnt2");
        expect_out("cnt2_const", 1'b1, 1'b1, 32'h100);
        for (int k = 0; k < 3; k++) upd(32'h40, 32'h40, 1'b0, 32'h0, "sat_down");
        upd(32'h40, 32'h40, 1'b1, 32'h100, "from_zero");
        look(32'h40, "no_underflow");
        expect_out("no_underflow_const", 1'b1, 1'b0, 32'h100);

        look(32'h140, "alias_miss");
        expect_out("alias_miss_const", 1'b0, 1'b0, 32'h0);
        upd(32'h40, 32'h140, 1'b0, 32'h0, "alias_nt");
        look(32'h40, "alias_nt_keep");
        expect_out("alias_nt_keep_const", 1'b1, 1'b0, 32'h100);
        upd(32'h40, 32'h140, 1'b1, 32'h200, "alias_alloc");
        look(32'h40, "evicted");
        expect_out("evicted_const", 1'b0, 1'b0, 32'h0);
        look(32'h140, "alias_hit");
        expect_out("alias_hit_const", 1'b1, 1'b1, 32'h200);

        upd(32'h40, 32'h40, 1'b1, 32'h100, "realloc");
        upd(32'h40, 32'h40, 1'b1, 32'h300, "collide");
        expect_out("collide_const", 1'b1, 1'b1, 32'h100);
        look(32'h40, "after_collide");
        expect_out("after_collide_const", 1'b1, 1'b1, 32'h300);

        step(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h400, 1'b1, "flush_edge");
        expect_out("flush_edge_const", 1'b1, 1'b1, 32'h300);
        look(32'h80, "flush_upd_miss");
        expect_out("flush_upd_miss_const", 1'b0, 1'b0, 32'h0);
        look(32'h40, "flush_miss");

        upd(32'h40, 32'h40, 1'b1, 32'h500, "pre_stall_alloc");
        look(32'h40, "pre_stall");
        for (int k = 0; k < 3; k++)
            step(1'b0, 32'h80 + 32'(k * 4), 1'b1, 32'h40, 1'b1, 32'h600, k[0], "stall");
        expect_out("stall_hold_const", 1'b1, 1'b1, 32'h500);
        look(32'h40, "post_stall");
        expect_out("post_stall_const", 1'b1, 1'b1, 32'h500);

        #2 w_rst_n = 1'b0;
        model_reset();
        #1;
        expect_out("midop_reset", 1'b0, 1'b0, 32'h0);
        #2 w_rst_n = 1'b1;
        look(32'h40, "after_reset");

        for (int n = 0; n < 400; n++) begin
            rpc = ($urandom % 4) * 32'h100 + ($urandom % 4) * 4 + ($urandom % 4);
            rup = ($urandom % 4) * 32'h100 + ($urandom % 4) * 4 + ($urandom % 4);
            step(($urandom % 8) != 0, rpc, ($urandom % 4) != 0, rup, $urandom % 2,
                 $urandom, ($urandom % 32) == 0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
